// File: rtl/microroc_slow_control_loader.sv
// Serialises one ASIC chain's slow-control or read-scope image into the MICROROC
// daisy-chained shift register, with an optional readback pass that checks the chain output.
module microroc_slow_control_loader #(
    parameter int PARAM_WIDTH = 592,
    parameter int READ_WIDTH  = 64,
    parameter int CHIPS       = 4,
    parameter int CLK_DIV     = 4,
    parameter int RST_CYCLES  = 16
) (
    input  logic                   Clk,
    input  logic                   reset_n,
    input  logic                   LoadStart,
    input  logic                   SlowOrReadScopeSelect,
    input  logic                   VerifyEnable,
    input  logic [PARAM_WIDTH-1:0] ParameterVector,
    input  logic [READ_WIDTH-1:0]  ReadScopeVector,
    input  logic                   SrOut,
    output logic                   SrClk,
    output logic                   SrIn,
    output logic                   SrReset_n,
    output logic                   SrSelect,
    output logic                   LoadBusy,
    output logic                   LoadDone,
    output logic                   VerifyError,
    output logic [15:0]            ErrorCount
);

    localparam int VEC_W   = (PARAM_WIDTH > READ_WIDTH) ? PARAM_WIDTH : READ_WIDTH;
    localparam int IDX_W   = (VEC_W > 1) ? $clog2(VEC_W) : 1;
    localparam int CHIP_W  = (CHIPS > 1) ? $clog2(CHIPS) : 1;
    localparam int TMR_MAX = (CLK_DIV > RST_CYCLES) ? CLK_DIV : RST_CYCLES;
    localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;

    localparam logic [TMR_W-1:0]  DIV_LAST   = TMR_W'(CLK_DIV - 1);
    localparam logic [TMR_W-1:0]  RST_LAST   = TMR_W'(RST_CYCLES - 1);
    localparam logic [IDX_W-1:0]  PARAM_LAST = IDX_W'(PARAM_WIDTH - 1);
    localparam logic [IDX_W-1:0]  READ_LAST  = IDX_W'(READ_WIDTH - 1);
    localparam logic [CHIP_W-1:0] CHIP_LAST  = CHIP_W'(CHIPS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SR_RESET,
        S_SHIFT_LOW,
        S_SHIFT_HIGH,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [TMR_W-1:0]   r_timer;
    logic [IDX_W-1:0]   r_bit_idx;
    logic [IDX_W-1:0]   r_last_idx;
    logic [CHIP_W-1:0]  r_chip;
    logic               r_pass;
    logic               r_verify;
    logic [VEC_W-1:0]   r_vec;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_sr_clk;
    logic               r_sr_in;
    logic               r_sr_reset_n;
    logic               r_sel;
    logic               r_busy;
    logic               r_done;
    logic               r_verify_err;
    logic [15:0]        r_err_cnt;

    logic               w_start;
    logic               w_bit_last;
    logic               w_chip_last;
    logic               w_pass_last;
    logic               w_mismatch;
    logic [IDX_W-1:0]   w_next_idx;

    assign w_start     = (r_state == S_IDLE) && LoadStart;
    assign w_bit_last  = (r_bit_idx == '0);
    assign w_chip_last = (r_chip == CHIP_LAST);
    assign w_pass_last = (r_pass == r_verify);
    assign w_mismatch  = (r_sync2 != r_sr_in);

    // NOTE: every variable assigned in always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_idx = r_bit_idx - 1'b1;
        if (w_bit_last) begin
            w_next_idx = r_last_idx;
        end
    end

    // NOTE: the image register is pure data qualified by the FSM, so it carries no reset.
    always_ff @(posedge Clk) begin
        if (w_start) begin
            r_vec <= SlowOrReadScopeSelect ? VEC_W'(ParameterVector) : VEC_W'(ReadScopeVector);
        end
    end

    // SrOut is asynchronous to Clk; only r_sync2 is used by the checker.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b0;
            r_sync2 <= 1'b0;
        end else begin
            r_sync1 <= SrOut;
            r_sync2 <= r_sync1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
    always_ff @(posedge Clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_timer      <= '0;
            r_bit_idx    <= '0;
            r_last_idx   <= '0;
            r_chip       <= '0;
            r_pass       <= 1'b0;
            r_verify     <= 1'b0;
            r_sr_clk     <= 1'b0;
            r_sr_in      <= 1'b0;
            r_sr_reset_n <= 1'b1;
            r_sel        <= 1'b0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_verify_err <= 1'b0;
            r_err_cnt    <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (LoadStart) begin
                        r_sel        <= SlowOrReadScopeSelect;
                        r_verify     <= VerifyEnable;
                        r_last_idx   <= SlowOrReadScopeSelect ? PARAM_LAST : READ_LAST;
                        r_bit_idx    <= SlowOrReadScopeSelect ? PARAM_LAST : READ_LAST;
                        r_chip       <= '0;
                        r_pass       <= 1'b0;
                        r_timer      <= '0;
                        r_busy       <= 1'b1;
                        r_verify_err <= 1'b0;
                        r_err_cnt    <= '0;
                        r_sr_reset_n <= 1'b0;
                        r_state      <= S_SR_RESET;
                    end
                end

                S_SR_RESET: begin
                    if (r_timer == RST_LAST) begin
                        r_timer      <= '0;
                        r_sr_reset_n <= 1'b1;
                        r_sr_in      <= r_vec[r_bit_idx];
                        r_state      <= S_SHIFT_LOW;
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_SHIFT_LOW: begin
                    if (r_timer == DIV_LAST) begin
                        r_timer  <= '0;
                        r_sr_clk <= 1'b1;
                        r_state  <= S_SHIFT_HIGH;
                        // Readback: the chain output now holds the bit we are presenting.
                        if (r_pass && w_mismatch) begin
                            r_verify_err <= 1'b1;
                            if (r_err_cnt != 16'hFFFF) begin
                                r_err_cnt <= r_err_cnt + 16'd1;
                            end
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_SHIFT_HIGH: begin
                    if (r_timer == DIV_LAST) begin
                        r_timer   <= '0;
                        r_sr_clk  <= 1'b0;
                        r_bit_idx <= w_next_idx;
                        if (w_bit_last) begin
                            r_chip <= w_chip_last ? '0 : r_chip + 1'b1;
                            if (w_chip_last) begin
                                r_pass <= ~r_pass;
                            end
                        end
                        if (w_bit_last && w_chip_last && w_pass_last) begin
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_sr_in <= r_vec[w_next_idx];
                            r_state <= S_SHIFT_LOW;
                        end
                    end else begin
                        r_timer <= r_timer + 1'b1;
                    end
                end

                S_DONE: begin
                    r_state <= S_IDLE;
                end

                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign SrClk       = r_sr_clk;
    assign SrIn        = r_sr_in;
    assign SrReset_n   = r_sr_reset_n;
    assign SrSelect    = r_sel;
    assign LoadBusy    = r_busy;
    assign LoadDone    = r_done;
    assign VerifyError = r_verify_err;
    assign ErrorCount  = r_err_cnt;

endmodule

// File: tb/tb_microroc_slow_control_loader.sv
// Directed bench for microroc_slow_control_loader: a 2-chip, 16-bit chain model clocked on
// SrClk rises supplies the readback stream and records what the loader shifted in.
module tb_microroc_slow_control_loader;

    localparam int PW = 16;
    localparam int RW = 8;
    localparam int CH = 2;
    localparam int CD = 4;
    localparam int RC = 16;

    typedef struct {
        bit          sel;
        bit          ver;
        bit          inj;
        logic [15:0] pv;
        logic [7:0]  rv;
        int          exp_rises;
        int          exp_busy;
        logic [31:0] exp_stream;
        int          len;
        logic        exp_verr;
        int          exp_ecnt;
    } vec_t;

    logic          Clk = 1'b0;
    logic          reset_n = 1'b1;
    logic          LoadStart = 1'b0;
    logic          sel = 1'b0;
    logic          ver = 1'b0;
    logic [PW-1:0] pvec = '0;
    logic [RW-1:0] rvec = '0;
    logic          SrOut;
    logic          SrClk, SrIn, SrReset_n, SrSelect, LoadBusy, LoadDone, VerifyError;
    logic [15:0]   ErrorCount;

    microroc_slow_control_loader #(
        .PARAM_WIDTH(PW), .READ_WIDTH(RW), .CHIPS(CH), .CLK_DIV(CD), .RST_CYCLES(RC)
    ) dut (
        .Clk(Clk), .reset_n(reset_n), .LoadStart(LoadStart),
        .SlowOrReadScopeSelect(sel), .VerifyEnable(ver),
        .ParameterVector(pvec), .ReadScopeVector(rvec), .SrOut(SrOut),
        .SrClk(SrClk), .SrIn(SrIn), .SrReset_n(SrReset_n), .SrSelect(SrSelect),
        .LoadBusy(LoadBusy), .LoadDone(LoadDone), .VerifyError(VerifyError),
        .ErrorCount(ErrorCount)
    );

    always #5 Clk = ~Clk;

    int          n_checks = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          rise_cnt = 0;
    int          done_cnt = 0;
    int          busy_cnt = 0;
    int          rst_low_cnt = 0;
    int          last_done_cyc = 0;
    int          rise_base = 0;
    bit          inject = 1'b0;
    bit          cap [0:1023];
    logic [31:0] model_sr = '0;
    logic        corrupt;

    // Chain model: 2 chips x 16 bits; optionally flips the output for pass-2 sample 5 of each chip.
    assign corrupt = inject && ((rise_cnt - rise_base) >= 32) && (((rise_cnt - rise_base - 32) % 16) == 5);
    assign SrOut   = model_sr[31] ^ corrupt;

    always @(posedge SrClk) begin
        model_sr      <= {model_sr[30:0], SrIn};
        cap[rise_cnt] <= SrIn;
        rise_cnt      <= rise_cnt + 1;
    end

    always @(posedge Clk) cyc <= cyc + 1;

    always @(negedge Clk) begin
        if (LoadBusy)   busy_cnt <= busy_cnt + 1;
        if (!SrReset_n) rst_low_cnt <= rst_low_cnt + 1;
        if (LoadDone) begin
            done_cnt      <= done_cnt + 1;
            last_done_cyc <= cyc;
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Starts one load and waits for LoadDone; restart_at pulses LoadStart again i cycles after the start.
    task automatic run_load(input vec_t v, input int restart_at,
                            output int o_rises, output int o_busy, output int o_rst,
                            output int o_off, output int o_dones, output logic [31:0] o_stream);
        int b_r, b_b, b_rst, b_d, start_cyc;
        bit seen;
        @(negedge Clk);
        sel = v.sel; ver = v.ver; pvec = v.pv; rvec = v.rv; inject = v.inj;
        rise_base = rise_cnt;
        b_r = rise_cnt; b_b = busy_cnt; b_rst = rst_low_cnt; b_d = done_cnt;
        LoadStart = 1'b1;
        @(negedge Clk);
        LoadStart = 1'b0;
        start_cyc = cyc;
        seen = 1'b0;
        for (int i = 1; i < 4000 && !seen; i++) begin
            @(negedge Clk);
            if (LoadDone) seen = 1'b1;
            LoadStart = (i == restart_at);
        end
        @(negedge Clk);
        LoadStart = 1'b0;
        check("done_seen", {31'd0, seen}, 32'd1);
        repeat (3) @(negedge Clk);
        o_rises  = rise_cnt - b_r;
        o_busy   = busy_cnt - b_b;
        o_rst    = rst_low_cnt - b_rst;
        o_dones  = done_cnt - b_d;
        o_off    = last_done_cyc - start_cyc;
        o_stream = '0;
        for (int k = 0; k < v.len; k++) o_stream = {o_stream[30:0], cap[b_r + k]};
    endtask

    vec_t        vecs [4];
    int          r_rises, r_busy, r_rst, r_off, r_dones, b_d, b_r;
    logic [31:0] r_stream;
    bit          hit;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 1'b0, 16'hA5C3, 8'h00, 32, 272, 32'hA5C3A5C3, 32, 1'b0, 0};
        vecs[1] = '{1'b1, 1'b1, 1'b0, 16'hA5C3, 8'h00, 64, 528, 32'hA5C3A5C3, 32, 1'b0, 0};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 16'hA5C3, 8'h00, 64, 528, 32'hA5C3A5C3, 32, 1'b1, 2};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 16'h1234, 8'h81, 16, 144, 32'h00008181, 16, 1'b0, 0};

        #2 reset_n = 1'b0;
        repeat (3) @(negedge Clk);
        check("rst_srclk",   {31'd0, SrClk},       32'd0);
        check("rst_srin",    {31'd0, SrIn},        32'd0);
        check("rst_srreset", {31'd0, SrReset_n},   32'd1);
        check("rst_select",  {31'd0, SrSelect},    32'd0);
        check("rst_busy",    {31'd0, LoadBusy},    32'd0);
        check("rst_done",    {31'd0, LoadDone},    32'd0);
        check("rst_verr",    {31'd0, VerifyError}, 32'd0);
        check("rst_ecnt",    {16'd0, ErrorCount},  32'd0);
        reset_n = 1'b1;
        repeat (2) @(negedge Clk);

        for (int i = 0; i < 4; i++) begin
            run_load(vecs[i], 0, r_rises, r_busy, r_rst, r_off, r_dones, r_stream);
            check($sformatf("v%0d_rises", i),   r_rises, vecs[i].exp_rises);
            check($sformatf("v%0d_busy", i),    r_busy, vecs[i].exp_busy);
            check($sformatf("v%0d_rstlow", i),  r_rst, RC);
            check($sformatf("v%0d_doneoff", i), r_off, vecs[i].exp_busy);
            check($sformatf("v%0d_dones", i),   r_dones, 1);
            check($sformatf("v%0d_stream", i),  r_stream, vecs[i].exp_stream);
            check($sformatf("v%0d_verr", i),    {31'd0, VerifyError}, {31'd0, vecs[i].exp_verr});
            check($sformatf("v%0d_ecnt", i),    {16'd0, ErrorCount}, vecs[i].exp_ecnt);
            check($sformatf("v%0d_select", i),  {31'd0, SrSelect}, {31'd0, vecs[i].sel});
            check($sformatf("v%0d_idle", i),    {31'd0, LoadBusy}, 32'd0);
        end

        // Second start while busy must not disturb the load.
        run_load(vecs[0], 40, r_rises, r_busy, r_rst, r_off, r_dones, r_stream);
        check("rb_rises",   r_rises, 32);
        check("rb_doneoff", r_off, 272);
        check("rb_busy",    r_busy, 272);
        check("rb_dones",   r_dones, 1);

        // Start held over the DONE cycle only must be ignored.
        run_load(vecs[0], 272, r_rises, r_busy, r_rst, r_off, r_dones, r_stream);
        check("rd_doneoff", r_off, 272);
        check("rd_dones",   r_dones, 1);
        check("rd_idle",    {31'd0, LoadBusy}, 32'd0);

        // Reset at the 10th SrClk rise aborts the load.
        @(negedge Clk);
        sel = 1'b1; ver = 1'b0; pvec = 16'hA5C3; inject = 1'b0;
        b_r = rise_cnt; b_d = done_cnt;
        LoadStart = 1'b1;
        @(negedge Clk);
        LoadStart = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 400 && !hit; i++) begin
            @(posedge Clk);
            #1;
            if (rise_cnt - b_r >= 10) hit = 1'b1;
        end
        check("ab_reached", {31'd0, hit}, 32'd1);
        reset_n = 1'b0;
        #1;
        check("ab_srclk",   {31'd0, SrClk},       32'd0);
        check("ab_srin",    {31'd0, SrIn},        32'd0);
        check("ab_srreset", {31'd0, SrReset_n},   32'd1);
        check("ab_select",  {31'd0, SrSelect},    32'd0);
        check("ab_busy",    {31'd0, LoadBusy},    32'd0);
        check("ab_done",    {31'd0, LoadDone},    32'd0);
        @(negedge Clk);
        reset_n = 1'b1;
        repeat (400) @(negedge Clk);
        check("ab_nodone", done_cnt - b_d, 0);
        check("ab_rises",  rise_cnt - b_r, 10);

        run_load(vecs[0], 0, r_rises, r_busy, r_rst, r_off, r_dones, r_stream);
        check("ar_rises",   r_rises, 32);
        check("ar_stream",  r_stream, 32'hA5C3A5C3);
        check("ar_rstlow",  r_rst, RC);
        check("ar_doneoff", r_off, 272);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
